frame_uart_tx: RTL and testbench
================================

# frame_uart_tx

Transmit-side counterpart of the UART pixel receive path. On `start`, this block reads a full frame of 24-bit RGB pixels from the frame buffer at addresses 0 to PIXELS-1. It splits each pixel into three bytes, R then G then B, and serializes them on `tx` as 8N1 UART. It sits between the frame buffer's read port and the board UART TX pin, and is used to dump captured or processed frames back to the host.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: UART bit rate. Bit period is BIT = CLK_FREQ/BAUD clocks, integer division, and BIT must be ≥ 2.
- `PIXELS`, default 40800: number of pixels per frame. PIXELS must be ≤ 65536.
- `clk` input 1: system clock. All logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: frame-send request. Sampled only in IDLE.
- `rd_en` output 1: frame-buffer read strobe, one-cycle pulse.
- `rd_addr` output 16: frame-buffer read address, 0 to PIXELS-1.
- `rd_data` input 24: pixel data `{R[23:16], G[15:8], B[7:0]}`. Valid exactly 1 clock after `rd_en`.
- `tx` output 1: UART serial out. Idles high.
- `busy` output 1: high from the cycle after `start` is accepted until frame completion.
- `frame_done` output 1: one-cycle pulse when the last stop bit of the frame completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `rd_en`=0, `rd_addr`=0, `frame_done`=0. FSM is in IDLE, pixel counter is 0, bit counters are 0.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
  - IDLE: `start`=1 → READ. `start` in any other state is ignored.
  - READ: `rd_en`=1 and `rd_addr`=pixel counter for exactly this cycle → WAIT.
  - WAIT: latch `rd_data` into a 24-bit pixel register, load byte index 0 → SEND.
  - SEND: transmit bytes R, G, B back-to-back. Each byte is framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). Each bit is held for BIT clocks. After the B stop bit:
    - if pixel counter = PIXELS-1 → DONE;
    - otherwise increment the pixel counter → READ.
  - DONE: `frame_done`=1 for this cycle only. `busy`=0 and pixel counter is cleared to 0 in this cycle → IDLE.
- `busy` is 1 in READ, WAIT and SEND, and 0 in IDLE and DONE.
- `tx` is driven from a register. It is 1 in IDLE, READ, WAIT and DONE, so it is glitch-free.
- Bit timing uses a down-counter reloaded with BIT-1 at each bit boundary. No separate baud-tick enable is shared with RX.
- The pixel counter is 16 bits and never wraps mid-frame. It is cleared on DONE and on reset.
- `rd_addr` holds its last value outside READ. Only `rd_en` qualifies it.

## Timing
- `start` is sampled high at edge E. READ is in the cycle after E, WAIT follows, and the R start bit begins the next cycle.
- Per-pixel cost is 2 + 30·BIT clocks. There is a 2-clock idle-high gap between pixels and no gap between bytes of the same pixel.
- Frame length is T = PIXELS·(2 + 30·BIT). The last stop bit ends after clock T counted from E. `frame_done` is high in cycle T+1, and `busy` is low from cycle T+1.
- A new `start` is accepted in IDLE, at the earliest the cycle after DONE.
- A `start` held high continuously starts back-to-back frames, separated by the DONE cycle and 1 IDLE cycle.
- Reset asserted mid-frame:
  - all outputs take their reset values immediately (asynchronously);
  - `tx` goes high, aborting the partial byte;
  - no `frame_done` is produced;
  - the next frame starts again at pixel 0.
- Read latency is fixed at 1 clock. The block does not support a frame buffer with longer latency.

## Test plan
- Waveform check, with CLK_FREQ=16, BAUD=1 (BIT=16) and PIXELS=4; memory holds pixel 0=0xA53C0F:
  - stimulus: pulse `start` once;
  - `rd_en` pulses with `rd_addr`=0 one cycle after `start`;
  - `tx` shows, 16 clocks per bit:
    - R byte: start 0, then 1,0,1,0,0,1,0,1, stop 1;
    - G byte: 0, 0,0,1,1,1,1,0,0, 1;
    - B byte: 0, 1,1,1,1,0,0,0,0, 1.
- Full frame, same parameters, 4 pixels:
  - `rd_addr` steps 0,1,2,3, each read 482 clocks apart;
  - `frame_done` is a single-cycle pulse 1929 clocks after `start`;
  - `busy` is high for exactly 1928 cycles;
  - a UART RX model decodes 12 bytes matching the memory contents in R,G,B order.
- `start` asserted repeatedly while `busy`=1 → no extra reads, byte stream unchanged, exactly one `frame_done`.
- Reset asserted during the G byte of pixel 1:
  - `tx`=1 and `busy`=0 immediately, with no `frame_done`;
  - a subsequent `start` re-reads from `rd_addr`=0.
- `start` held high for 2 frames → second frame's `rd_en` at `rd_addr`=0 occurs 2 cycles after the first `frame_done`; both frames decode identically.
- Default parameters (BIT=868) with PIXELS=2 → bit period 868 clocks ±0, frame length 2·(2+30·868)=52084 clocks.

Source files
------------

// File: rtl/frame_uart_tx_if.sv
// Frame-buffer read port plus UART/status signals of the frame transmitter.
// rd_en is a one-cycle read strobe qualifying rd_addr; rd_data is taken exactly one clock later (fixed latency, no back-pressure).
interface frame_uart_tx_if;
    logic        start;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [23:0] rd_data;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (
        input  start,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output tx,
        output busy,
        output frame_done
    );

    modport slave (
        output start,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/frame_uart_tx.sv
// Reads a frame of 24-bit RGB pixels and streams each as R,G,B bytes in 8N1 UART format.
// Two-clock read/latch gap between pixels; the three bytes of a pixel go back-to-back.
module frame_uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int PIXELS   = 40800
) (
    input  logic                   clk,
    input  logic                   reset,
    frame_uart_tx_if.master        bus,
    output logic [2:0]             state_o
);

    localparam int BIT = CLK_FREQ / BAUD;
    localparam int CW  = (BIT > 1) ? $clog2(BIT) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(BIT - 1);
    localparam logic [15:0]   LAST_PIXEL  = 16'(PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e        state_q,    state_d;
    logic [15:0]   pix_cnt_q,  pix_cnt_d;
    logic [15:0]   addr_q,     addr_d;
    logic [23:0]   pix_q,      pix_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [3:0]    bit_idx_q,  bit_idx_d;
    logic [CW-1:0] baud_q,     baud_d;
    logic          tx_q,       tx_d;
    logic [7:0]    cur_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            addr_q     <= '0;
            pix_q      <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        cur_byte = pix_q[23:16];
        case (byte_idx_q)
            2'd1:    cur_byte = pix_q[15:8];
            2'd2:    cur_byte = pix_q[7:0];
            default: cur_byte = pix_q[23:16];
        endcase
    end

    // tx_d is the level of the *next* bit, so tx_q changes exactly on bit boundaries.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        addr_d     = addr_q;
        pix_d      = pix_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        tx_d       = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.start) begin
                    addr_d  = pix_cnt_q;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                pix_d      = bus.rd_data;
                byte_idx_d = 2'd0;
                bit_idx_d  = 4'd0;
                baud_d     = BAUD_RELOAD;
                tx_d       = 1'b0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CW'(1);
                end else begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 4'd9) begin
                        bit_idx_d = 4'd0;
                        if (byte_idx_q == 2'd2) begin
                            tx_d       = 1'b1;
                            byte_idx_d = 2'd0;
                            baud_d     = '0;
                            if (pix_cnt_q == LAST_PIXEL) begin
                                state_d = S_DONE;
                            end else begin
                                pix_cnt_d = pix_cnt_q + 16'd1;
                                addr_d    = pix_cnt_q + 16'd1;
                                state_d   = S_READ;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            tx_d       = 1'b0;
                        end
                    end else if (bit_idx_q == 4'd8) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = cur_byte[bit_idx_q[2:0]];
                    end
                end
            end
            S_DONE: begin
                pix_cnt_d = '0;
                tx_d      = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.rd_en      = (state_q == S_READ);
    assign bus.rd_addr    = addr_q;
    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
    assign bus.frame_done = (state_q == S_DONE);
    assign state_o        = state_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: small-BIT instance for waveform/frame/corner checks,
// plus a default-baud instance timing a 2-pixel frame in parallel.
module tb_frame_uart_tx;

    localparam int BIT   = 16;
    localparam int PCOST = 2 + 30 * BIT;    // 482
    localparam int TLEN  = 4 * PCOST;       // 1928

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       reset2;
    logic [2:0] state_dbg;
    logic [2:0] state_dbg2;

    frame_uart_tx_if bus1();
    frame_uart_tx_if bus2();

    frame_uart_tx #(.CLK_FREQ(16), .BAUD(1), .PIXELS(4)) dut (
        .clk(clk), .reset(reset), .bus(bus1), .state_o(state_dbg)
    );

    frame_uart_tx #(.PIXELS(2)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2), .state_o(state_dbg2)
    );

    logic [23:0] mem [0:3];

    always @(posedge clk) if (bus1.rd_en) bus1.rd_data <= mem[bus1.rd_addr[1:0]];
    always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= 24'h010101;

    int n_checks = 0;
    int n_errors = 0;
    bit done2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic        log_tx   [0:4095];
    logic        log_busy [0:4095];
    logic        log_rd   [0:4095];
    logic [15:0] log_addr [0:4095];
    logic        log_done [0:4095];

    // mode 0: single start pulse; 1: start toggled while busy; 2: start held ~2 frames
    task automatic record(input int ncyc, input int mode);
        @(negedge clk);
        bus1.start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            log_tx[c]   = bus1.tx;
            log_busy[c] = bus1.busy;
            log_rd[c]   = bus1.rd_en;
            log_addr[c] = bus1.rd_addr;
            log_done[c] = bus1.frame_done;
            case (mode)
                1:       bus1.start = (c < 1900) && (c % 3 == 0);
                2:       bus1.start = (c < 2000);
                default: bus1.start = 1'b0;
            endcase
        end
        bus1.start = 1'b0;
    endtask

    logic [7:0] dec    [0:31];
    logic       dec_ok [0:31];
    int         dec_n;

    // UART receiver over the log: detect a start bit, sample every bit mid-period.
    task automatic decode(input int last);
        int c;
        logic [7:0] b;
        dec_n = 0;
        c = 1;
        while (c + 151 <= last) begin
            if (log_tx[c] == 1'b0) begin
                for (int i = 0; i < 8; i++) b[i] = log_tx[c + 7 + 16 * (i + 1)];
                if (dec_n < 32) begin
                    dec[dec_n]    = b;
                    dec_ok[dec_n] = (log_tx[c + 7] == 1'b0) && (log_tx[c + 151] == 1'b1);
                end
                dec_n++;
                c = c + 160;
            end else begin
                c++;
            end
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [23:0] p;
        p = mem[(k / 3) % 4];
        case (k % 3)
            0:       return p[23:16];
            1:       return p[15:8];
            default: return p[7:0];
        endcase
    endfunction

    task automatic check_stream(input string tag, input int nbytes);
        check({tag, "_nbytes"}, dec_n, nbytes);
        for (int k = 0; k < nbytes && k < dec_n; k++) begin
            check($sformatf("%s_byte%0d", tag, k), {dec_ok[k], dec[k]}, {1'b1, exp_byte(k)});
        end
    endtask

    task automatic count_log(input int last, output int n_rd, output int n_done, output int n_busy);
        n_rd = 0; n_done = 0; n_busy = 0;
        for (int c = 1; c <= last; c++) begin
            if (log_rd[c])   n_rd++;
            if (log_done[c]) n_done++;
            if (log_busy[c]) n_busy++;
        end
    endtask

    typedef struct {
        int          cyc;
        logic        tx;
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic        done;
    } vec_t;

    vec_t vecs [0:22];

    initial begin
        int n_rd, n_done, n_busy;

        mem[0] = 24'hA53C0F;
        mem[1] = 24'h123456;
        mem[2] = 24'hFF0080;
        mem[3] = 24'h00A5FF;

        // cycle counted from the start-sampling edge: 1=READ, 2=WAIT, 3=first start bit
        vecs[0]  = '{1,    1'b1, 1'b1, 1'b1, 16'd0, 1'b0};
        vecs[1]  = '{2,    1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[2]  = '{3,    1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[3]  = '{18,   1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[4]  = '{19,   1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[5]  = '{35,   1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[6]  = '{51,   1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[7]  = '{147,  1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[8]  = '{162,  1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[9]  = '{163,  1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[10] = '{211,  1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[11] = '{403,  1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[12] = '{482,  1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        vecs[13] = '{483,  1'b1, 1'b1, 1'b1, 16'd1, 1'b0};
        vecs[14] = '{484,  1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        vecs[15] = '{485,  1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
        vecs[16] = '{501,  1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
        vecs[17] = '{517,  1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        vecs[18] = '{965,  1'b1, 1'b1, 1'b1, 16'd2, 1'b0};
        vecs[19] = '{1447, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0};
        vecs[20] = '{1928, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0};
        vecs[21] = '{1929, 1'b1, 1'b0, 1'b0, 16'd3, 1'b1};
        vecs[22] = '{1930, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0};

        // reset
        reset = 1'b1;
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", bus1.tx, 1'b1);
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_rd_en", bus1.rd_en, 1'b0);
        check("rst_rd_addr", bus1.rd_addr, 16'd0);
        check("rst_done", bus1.frame_done, 1'b0);
        check("rst_state", state_dbg, 3'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_tx", bus1.tx, 1'b1);
        check("idle_busy", bus1.busy, 1'b0);

        // frame A: single start pulse, vector table + receiver
        record(1935, 0);
        foreach (vecs[i]) begin
            check($sformatf("A_c%0d_tx", vecs[i].cyc),   log_tx[vecs[i].cyc],   vecs[i].tx);
            check($sformatf("A_c%0d_busy", vecs[i].cyc), log_busy[vecs[i].cyc], vecs[i].busy);
            check($sformatf("A_c%0d_rd", vecs[i].cyc),   log_rd[vecs[i].cyc],   vecs[i].rd);
            check($sformatf("A_c%0d_addr", vecs[i].cyc), log_addr[vecs[i].cyc], vecs[i].addr);
            check($sformatf("A_c%0d_done", vecs[i].cyc), log_done[vecs[i].cyc], vecs[i].done);
        end
        count_log(1935, n_rd, n_done, n_busy);
        check("A_reads", n_rd, 4);
        check("A_done_pulses", n_done, 1);
        check("A_busy_cycles", n_busy, TLEN);
        decode(1935);
        check_stream("A", 12);

        // frame B: start toggled while busy
        record(1935, 1);
        count_log(1935, n_rd, n_done, n_busy);
        check("B_reads", n_rd, 4);
        check("B_done_pulses", n_done, 1);
        check("B_done_cycle", log_done[TLEN + 1], 1'b1);
        check("B_busy_cycles", n_busy, TLEN);
        decode(1935);
        check_stream("B", 12);

        // reset during G byte of pixel 1 (cycles 645..804)
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (699) @(negedge clk);
        check("mid_busy_before", bus1.busy, 1'b1);
        check("mid_addr_before", bus1.rd_addr, 16'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", bus1.tx, 1'b1);
        check("mid_rst_busy", bus1.busy, 1'b0);
        check("mid_rst_rd_en", bus1.rd_en, 1'b0);
        check("mid_rst_rd_addr", bus1.rd_addr, 16'd0);
        check("mid_rst_done", bus1.frame_done, 1'b0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) reset = 1'b0;
            if (bus1.frame_done) n_done++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus1.frame_done) n_done++;
        end
        check("mid_no_done", n_done, 0);
        record(4, 0);
        check("restart_rd_en", log_rd[1], 1'b1);
        check("restart_addr", log_addr[1], 16'd0);
        check("restart_tx_start", log_tx[3], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // start held: two back-to-back frames
        record(3870, 2);
        count_log(3870, n_rd, n_done, n_busy);
        check("H_reads", n_rd, 8);
        check("H_done_pulses", n_done, 2);
        check("H_done1", log_done[TLEN + 1], 1'b1);
        check("H_idle_gap_rd", log_rd[TLEN + 2], 1'b0);
        check("H_rd2", log_rd[TLEN + 3], 1'b1);
        check("H_rd2_addr", log_addr[TLEN + 3], 16'd0);
        check("H_done2", log_done[2 * TLEN + 3], 1'b1);
        decode(3870);
        check_stream("H", 24);

        for (int i = 0; i < 60000 && !done2; i++) @(negedge clk);
        check("dflt_finished", done2, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // default BIT=868, PIXELS=2: bit period and frame length
    initial begin
        int first_low, low_len, busy_cnt, done_cyc, rd2_cyc;
        bit low_run;
        reset2 = 1'b1;
        bus2.start = 1'b0;
        first_low = 0; low_len = 0; busy_cnt = 0; done_cyc = 0; rd2_cyc = 0;
        low_run = 1'b0;
        repeat (3) @(negedge clk);
        reset2 = 1'b0;
        @(negedge clk);
        bus2.start = 1'b1;
        for (int c = 1; c <= 52100; c++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            if (bus2.busy) busy_cnt++;
            if (bus2.frame_done && done_cyc == 0) done_cyc = c;
            if (bus2.rd_en && c > 1 && rd2_cyc == 0) rd2_cyc = c;
            if (first_low == 0 && bus2.tx == 1'b0) begin
                first_low = c;
                low_run = 1'b1;
            end
            if (low_run) begin
                if (bus2.tx == 1'b0) low_len++;
                else low_run = 1'b0;
            end
        end
        check("dflt_first_low", first_low, 3);
        check("dflt_bit_period", low_len, 868);
        check("dflt_rd2_cycle", rd2_cyc, 26043);
        check("dflt_busy_cycles", busy_cnt, 52084);
        check("dflt_done_cycle", done_cyc, 52085);
        done2 = 1'b1;
    end

endmodule
